fix_point_accumulator: RTL and testbench

Sequential accumulate stage directly downstream of MUL_FIX_POINT_FLOAT. It consumes a stream of signed Q8.8 products, where 16'h0100 = 1.0. It sums one neuron's products over a packet delimited by in_last. It then emits one saturated Q8.8 neuron pre-activation per packet, with valid/ready handshakes on both sides.

---
 rtl/fix_point_pkg.sv | 16 +
 rtl/fix_point_accumulator_sat_narrow.sv | 25 ++
 rtl/fix_point_accumulator.sv | 113 +++++++++++
 tb/tb_fix_point_accumulator.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fix_point_pkg.sv
// Shared Q8.8 constants and accumulator state encoding for the fixed-point datapath.
package fix_point_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;

  localparam logic [DATA_W-1:0] Q88_ONE = 16'h0100;
  localparam logic [DATA_W-1:0] Q88_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q88_MIN = 16'h8000;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/fix_point_accumulator_sat_narrow.sv
// Purpose: combinational signed saturation from IN_W to OUT_W bits, with a clip flag.
// Latency: 0 cycles. Backpressure: none, pure combinational.
module sat_narrow #(
  parameter int IN_W  = 25,
  parameter int OUT_W = 24
) (
  input  logic [IN_W-1:0]  in_dat,
  output logic [OUT_W-1:0] out_dat,
  output logic             clip_flag
);

  // Bits that must all match the sign for the value to fit in OUT_W.
  logic [IN_W-OUT_W:0] top_bits;
  assign top_bits = in_dat[IN_W-1:OUT_W-1];

  always_comb begin
    clip_flag = !((&top_bits) || !(|top_bits));
    out_dat   = in_dat[OUT_W-1:0];
    if (clip_flag) begin
      out_dat = in_dat[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fix_point_accumulator.sv
// Purpose: sums signed Q8.8 products per in_last-delimited packet into one saturated Q8.8 result.
// Latency: result valid the cycle after the last beat is accepted. Backpressure: in_ready low while a result waits.
// Optional FIX_POINT_ACC_RELU_EN clamps negative results to zero (out_sat unaffected).
module fix_point_accumulator #(
  parameter int DATA_W  = fix_point_pkg::DATA_W,
  parameter int FRAC_W  = fix_point_pkg::FRAC_W,
  parameter int GUARD_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat
);

  import fix_point_pkg::*;

  localparam int ACC_W = DATA_W + GUARD_W;

  // FRAC_W only documents the Q format: sums of equal-scale values need no rescale.
  if (FRAC_W >= DATA_W) begin : g_frac_w_exceeds_data_w
  end

  acc_state_t        state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic              sticky;

  logic [ACC_W:0]    sum_wide;
  logic [ACC_W-1:0]  acc_nxt;
  logic              acc_clip;
  logic [DATA_W-1:0] narrow_dat;
  logic              narrow_clip;
  logic [DATA_W-1:0] res_dat;
  logic [CNT_W-1:0]  cnt_inc;

  // One extra bit so the add itself can never wrap before saturation.
  assign sum_wide = {acc[ACC_W-1], acc} + {{(GUARD_W+1){in_data[DATA_W-1]}}, in_data};

  sat_narrow #(
    .IN_W  (ACC_W+1),
    .OUT_W (ACC_W)
  ) u_acc_sat (
    .in_dat    (sum_wide),
    .out_dat   (acc_nxt),
    .clip_flag (acc_clip)
  );

  sat_narrow #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_out_sat (
    .in_dat    (acc_nxt),
    .out_dat   (narrow_dat),
    .clip_flag (narrow_clip)
  );

`ifdef FIX_POINT_ACC_RELU_EN
  assign res_dat = narrow_dat[DATA_W-1] ? '0 : narrow_dat;
`else
  assign res_dat = narrow_dat;
`endif

  assign cnt_inc   = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (in_last) begin
              out_data  <= res_dat;
              out_count <= cnt_inc;
              out_sat   <= sticky | acc_clip | narrow_clip;
              acc       <= '0;
              cnt       <= '0;
              sticky    <= 1'b0;
              state     <= HOLD;
            end else begin
              acc    <= acc_nxt;
              cnt    <= cnt_inc;
              sticky <= sticky | acc_clip;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_fix_point_accumulator.sv
// Directed and randomized packets against a plain-arithmetic reference of the saturating accumulate.
module tb_fix_point_accumulator;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [7:0]  out_count;
  logic        out_sat;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] pkt [0:511];
  int          pkt_len;

  fix_point_accumulator dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: exact integer sum clamped to the 24-bit accumulator range, then to Q8.8.
  task automatic model(output logic [15:0] d, output logic [31:0] c, output logic s);
    longint acc;
    bit     st;
    acc = 0;
    st  = 1'b0;
    for (int i = 0; i < pkt_len; i++) begin
      acc = acc + longint'($signed(pkt[i]));
      if (acc > 64'sd8388607) begin
        acc = 8388607;
        st  = 1'b1;
      end else if (acc < -64'sd8388608) begin
        acc = -8388608;
        st  = 1'b1;
      end
    end
    if (acc > 32767) begin
      d  = 16'h7FFF;
      st = 1'b1;
    end else if (acc < -32768) begin
      d  = 16'h8000;
      st = 1'b1;
    end else begin
      d = 16'(acc);
    end
`ifdef FIX_POINT_ACC_RELU_EN
    if (d[15]) d = 16'h0000;
`endif
    c = (pkt_len > 255) ? 32'd255 : 32'(pkt_len);
    s = st;
  endtask

  task automatic run_packet(input int hold, input string tag);
    logic [15:0] ed;
    logic [31:0] ec;
    logic        es;
    int          guard;
    model(ed, ec, es);
    out_ready = (hold == 0);
    for (int i = 0; i < pkt_len; i++) begin
      in_valid = 1'b1;
      in_data  = pkt[i];
      in_last  = (i == pkt_len - 1);
      guard    = 0;
      while (!in_ready && guard < 20) begin
        step();
        guard++;
      end
      if (!in_ready) begin
        check({tag, "_in_ready_timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_out_data"},  32'(out_data),  32'(ed));
    check({tag, "_out_count"}, 32'(out_count), ec);
    check({tag, "_out_sat"},   32'(out_sat),   32'(es));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 16'h1234;
      in_last  = 1'b1;
      step();
      check({tag, "_hold_valid"},    32'(out_valid), 32'd1);
      check({tag, "_hold_data"},     32'(out_data),  32'(ed));
      check({tag, "_hold_count"},    32'(out_count), ec);
      check({tag, "_hold_in_ready"}, 32'(in_ready),  32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_sat",   32'(out_sat),   32'd0);
    RST_N = 1'b1;
    step();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    pkt[0] = 16'h0100; pkt[1] = 16'h0200; pkt[2] = 16'hFE00; pkt_len = 3;
    run_packet(0, "three_beat");

    pkt[0] = 16'h7000; pkt[1] = 16'h7000; pkt_len = 2;
    run_packet(0, "pos_ovf");
    pkt[0] = 16'h0080; pkt_len = 1;
    run_packet(0, "after_pos_ovf");

    pkt[0] = 16'h8000; pkt[1] = 16'h8000; pkt_len = 2;
    run_packet(0, "neg_ovf");

    pkt[0] = 16'h0300; pkt_len = 1;
    run_packet(5, "backpressure");
    pkt[0] = 16'h0040; pkt[1] = 16'h0001; pkt_len = 2;
    run_packet(0, "after_bp");

    // Partial packet discarded by reset.
    in_valid = 1'b1; in_data = 16'h0100; in_last = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    #2;
    RST_N = 1'b0;
    #2;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    step();
    RST_N = 1'b1;
    step();
    check("mid_rst_no_output", 32'(out_valid), 32'd0);
    pkt[0] = 16'hFF00; pkt_len = 1;
    run_packet(0, "after_mid_rst");

    // Back-to-back streaming, lengths 1, 4, 2.
    pkt_len = 1;
    pkt[0] = 16'($urandom);
    run_packet(0, "stream_len1");
    pkt_len = 4;
    for (int i = 0; i < 4; i++) pkt[i] = 16'($urandom_range(0, 16'h0400)) - 16'h0200;
    run_packet(0, "stream_len4");
    pkt_len = 2;
    for (int i = 0; i < 2; i++) pkt[i] = 16'($urandom);
    run_packet(0, "stream_len2");

    // Long packet: counter and accumulator both saturate.
    pkt_len = 300;
    for (int i = 0; i < 300; i++) pkt[i] = 16'h7FFF;
    run_packet(1, "long_pos");
    for (int i = 0; i < 300; i++) pkt[i] = 16'h8000;
    run_packet(0, "long_neg");

    for (int p = 0; p < 30; p++) begin
      pkt_len = $urandom_range(1, 8);
      for (int i = 0; i < pkt_len; i++) begin
        if ($urandom_range(0, 1) == 0) pkt[i] = 16'($urandom);
        else pkt[i] = 16'($urandom_range(0, 16'h0800)) - 16'h0400;
      end
      run_packet($urandom_range(0, 3), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
